// File: rtl/mna_pkg.sv
// Shared definitions for the master network adapter response path:
// flit type codes, header field positions, AXI response codes and FSM states.
package mna_pkg;

    localparam logic [1:0] FLIT_IDLE = 2'b00;
    localparam logic [1:0] FLIT_DATA = 2'b01;
    localparam logic [1:0] FLIT_HDR  = 2'b10;
    localparam logic [1:0] FLIT_RSVD = 2'b11;

    localparam int WR_BIT   = 0;
    localparam int RESP_LSB = 1;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_SEND_B    = 2'd2,
        ST_SEND_R    = 2'd3
    } state_e;

endpackage

// File: rtl/mna_resp_watchdog.sv
// Read-data watchdog: clearable up-counter that flags expiry when it reaches
// TIMEOUT. TIMEOUT = 0 disables expiry entirely.
module mna_resp_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mna_response_sequencer.sv
// Turns NoC response flits into AXI4-Lite B/R beats, one response at a time,
// with a watchdog that completes a stalled read as SLVERR.
module mna_response_sequencer
    import mna_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] flit_data,
    input  logic              flit_valid,
    output logic              flit_ready,
    output logic              m_bvalid,
    output logic [1:0]        m_bresp,
    input  logic              m_bready,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        m_rresp,
    input  logic              m_rready,
    output logic              proto_err,
    output logic              timeout_err
);

    state_e              state, state_n;
    logic [1:0]          rd_resp, rd_resp_n;
    logic                bvalid_n, rvalid_n;
    logic [1:0]          bresp_n, rresp_n;
    logic [DATA_W-1:0]   rdata_n;
    logic                proto_n, timeout_n;
    logic                wd_clear, wd_inc, wd_expired;

    logic [1:0] flit_type;
    logic [1:0] hdr_resp;
    logic       hdr_write;
    logic       accept;

    assign flit_type  = flit_data[DATA_W+1:DATA_W];
    assign hdr_resp   = flit_data[RESP_LSB +: 2];
    assign hdr_write  = flit_data[WR_BIT];
    assign flit_ready = (state == ST_IDLE) || (state == ST_WAIT_DATA);
    assign accept     = flit_valid && flit_ready;

    mna_resp_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n   = state;
        rd_resp_n = rd_resp;
        bvalid_n  = m_bvalid;
        bresp_n   = m_bresp;
        rvalid_n  = m_rvalid;
        rdata_n   = m_rdata;
        rresp_n   = m_rresp;
        proto_n   = 1'b0;
        timeout_n = 1'b0;
        wd_clear  = 1'b0;
        wd_inc    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (flit_type)
                        FLIT_HDR: begin
                            if (hdr_write) begin
                                bresp_n  = hdr_resp;
                                bvalid_n = 1'b1;
                                state_n  = ST_SEND_B;
                            end else begin
                                rd_resp_n = hdr_resp;
                                wd_clear  = 1'b1;
                                state_n   = ST_WAIT_DATA;
                            end
                        end
                        FLIT_DATA, FLIT_RSVD: proto_n = 1'b1;
                        FLIT_IDLE: ;
                    endcase
                end
            end

            ST_WAIT_DATA: begin
                if (accept && flit_type == FLIT_DATA) begin
                    // A data flit beats a watchdog expiry in the same cycle.
                    rdata_n  = flit_data[DATA_W-1:0];
                    rresp_n  = rd_resp;
                    rvalid_n = 1'b1;
                    state_n  = ST_SEND_R;
                end else begin
                    wd_inc = 1'b1;
                    if (accept && (flit_type == FLIT_HDR || flit_type == FLIT_RSVD)) begin
                        proto_n = 1'b1;
                    end
                    if (wd_expired) begin
                        rdata_n   = '0;
                        rresp_n   = AXI_SLVERR;
                        rvalid_n  = 1'b1;
                        timeout_n = 1'b1;
                        state_n   = ST_SEND_R;
                    end
                end
            end

            ST_SEND_B: begin
                if (m_bready) begin
                    bvalid_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end

            ST_SEND_R: begin
                if (m_rready) begin
                    rvalid_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_resp     <= AXI_OKAY;
            m_bvalid    <= 1'b0;
            m_bresp     <= AXI_OKAY;
            m_rvalid    <= 1'b0;
            m_rdata     <= '0;
            m_rresp     <= AXI_OKAY;
            proto_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            rd_resp     <= rd_resp_n;
            m_bvalid    <= bvalid_n;
            m_bresp     <= bresp_n;
            m_rvalid    <= rvalid_n;
            m_rdata     <= rdata_n;
            m_rresp     <= rresp_n;
            proto_err   <= proto_n;
            timeout_err <= timeout_n;
        end
    end

endmodule

// File: tb/tb_mna_response_sequencer.sv
// Directed bench for mna_response_sequencer (DATA_W=32, TIMEOUT=8) with
// hand-computed expectations checked by immediate assertions.
module tb_mna_response_sequencer;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W+1:0] flit_data;
    logic              flit_valid;
    logic              flit_ready;
    logic              m_bvalid;
    logic [1:0]        m_bresp;
    logic              m_bready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rready;
    logic              proto_err;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;
    int overlaps = 0;

    mna_response_sequencer #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flit_data   (flit_data),
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .m_bvalid    (m_bvalid),
        .m_bresp     (m_bresp),
        .m_bready    (m_bready),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rready    (m_rready),
        .proto_err   (proto_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_bvalid && m_rvalid) overlaps++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=no_finish expected=finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W+1:0] f);
        flit_data  = f;
        flit_valid = 1'b1;
    endtask

    task automatic idle_in();
        flit_data  = '0;
        flit_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        m_bready = 1'b0;
        m_rready = 1'b0;
        tick();
        tick();
        check("rst_flit_ready", flit_ready, 1);
        check("rst_bvalid", m_bvalid, 0);
        check("rst_rvalid", m_rvalid, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_resps", {m_bresp, m_rresp}, 0);
        check("rst_pulses", {proto_err, timeout_err}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", flit_ready, 1);

        // Write response with immediate B ready.
        m_bready = 1'b1;
        drive(34'h2_00000001);
        tick();
        idle_in();
        check("wr_bvalid", m_bvalid, 1);
        check("wr_bresp", m_bresp, 2'b00);
        check("wr_ready_low", flit_ready, 0);
        tick();
        check("wr_bvalid_clr", m_bvalid, 0);
        check("wr_ready_back", flit_ready, 1);
        m_bready = 1'b0;

        // Read with R stalled for three cycles.
        drive(34'h2_00000004);
        tick();
        check("rd_wait_ready", flit_ready, 1);
        check("rd_wait_novalid", m_rvalid, 0);
        drive(34'h1_DEADBEEF);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            check("rd_rvalid", m_rvalid, 1);
            check("rd_rdata", m_rdata, 32'hDEADBEEF);
            check("rd_rresp", m_rresp, 2'b10);
            check("rd_ready_low", flit_ready, 0);
            if (i < 3) tick();
        end
        m_rready = 1'b1;
        tick();
        check("rd_rvalid_clr", m_rvalid, 0);
        check("rd_ready_back", flit_ready, 1);
        m_rready = 1'b0;

        // Stray data flit in IDLE.
        drive(34'h1_12345678);
        tick();
        idle_in();
        check("stray_proto", proto_err, 1);
        check("stray_no_valid", {m_bvalid, m_rvalid}, 0);
        check("stray_ready", flit_ready, 1);
        tick();
        check("stray_proto_pulse", proto_err, 0);

        // Reserved flit while awaiting read data.
        drive(34'h2_00000000);
        tick();
        drive(34'h3_00000000);
        tick();
        check("rsvd_proto", proto_err, 1);
        check("rsvd_still_wait", flit_ready, 1);
        check("rsvd_no_rvalid", m_rvalid, 0);
        drive(34'h1_00000055);
        tick();
        idle_in();
        check("rsvd_data_rvalid", m_rvalid, 1);
        check("rsvd_data_rdata", m_rdata, 32'h55);
        check("rsvd_data_rresp", m_rresp, 2'b00);
        check("rsvd_proto_clr", proto_err, 0);
        m_rready = 1'b1;
        tick();
        check("rsvd_done", m_rvalid, 0);
        m_rready = 1'b0;

        // Watchdog expiry: WAIT_DATA cycles see counts 0..8, expiry at count 8.
        drive(34'h2_00000002);
        tick();
        idle_in();
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            check("to_no_rvalid", m_rvalid, 0);
            check("to_no_err", timeout_err, 0);
        end
        tick();
        check("to_rvalid", m_rvalid, 1);
        check("to_rdata", m_rdata, 0);
        check("to_rresp", m_rresp, 2'b10);
        check("to_err", timeout_err, 1);
        tick();
        check("to_err_pulse", timeout_err, 0);
        check("to_rvalid_hold", m_rvalid, 1);
        m_rready = 1'b1;
        tick();
        check("to_done", m_rvalid, 0);
        m_rready = 1'b0;

        // Data flit on the expiry cycle wins.
        drive(34'h2_00000000);
        tick();
        idle_in();
        for (int i = 0; i < TIMEOUT; i++) tick();
        drive(34'h1_CAFEF00D);
        tick();
        idle_in();
        check("race_rvalid", m_rvalid, 1);
        check("race_rdata", m_rdata, 32'hCAFEF00D);
        check("race_rresp", m_rresp, 2'b00);
        check("race_no_err", timeout_err, 0);
        m_rready = 1'b1;
        tick();
        check("race_done", m_rvalid, 0);
        m_rready = 1'b0;

        // Asynchronous reset while a read beat is pending.
        drive(34'h2_00000000);
        tick();
        drive(34'h1_0000ABCD);
        tick();
        idle_in();
        check("arst_pre_rvalid", m_rvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rvalid", m_rvalid, 0);
        check("arst_rdata", m_rdata, 0);
        check("arst_ready", flit_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        check("arst_rel_ready", flit_ready, 1);
        check("arst_rel_rvalid", m_rvalid, 0);

        // Back-to-back write, read, write with both readies held high.
        m_bready = 1'b1;
        m_rready = 1'b1;
        drive(34'h2_00000003);
        tick();
        check("b2b_w1_bvalid", m_bvalid, 1);
        check("b2b_w1_bresp", m_bresp, 2'b01);
        drive(34'h2_00000000);
        tick();
        check("b2b_w1_clr", m_bvalid, 0);
        check("b2b_idle_ready", flit_ready, 1);
        tick();
        drive(34'h1_11112222);
        tick();
        check("b2b_r_rvalid", m_rvalid, 1);
        check("b2b_r_rdata", m_rdata, 32'h11112222);
        check("b2b_r_rresp", m_rresp, 2'b00);
        drive(34'h2_00000007);
        tick();
        check("b2b_r_clr", m_rvalid, 0);
        tick();
        idle_in();
        check("b2b_w2_bvalid", m_bvalid, 1);
        check("b2b_w2_bresp", m_bresp, 2'b11);
        tick();
        check("b2b_w2_clr", m_bvalid, 0);
        check("no_b_r_overlap", overlaps, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
